// File: rtl/jk_mode_register.sv
// Multi-mode WIDTH-bit register: per-bit JK, up/down counter (wrap or saturate) and shift-left.
// Master-slave timing: all updates land on the falling clk edge; clr is asynchronous.
module jk_mode_register #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             tc,
   output logic             co
);

   typedef enum logic [1:0] {
      MODE_JK   = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_SHL  = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] q_p0;
   logic             co_p0;
   logic [WIDTH-1:0] q_nxt;
   logic             co_nxt;
   logic             at_max;
   logic             at_min;

   // JK characteristic equation, applied to every bit independently.
   function automatic logic [WIDTH-1:0] jk_update(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] jv,
      input logic [WIDTH-1:0] kv
   );
      return (jv & ~cur) | (~kv & cur);
   endfunction

   // At the top of the range the counter either wraps to zero or sticks.
   function automatic logic [WIDTH-1:0] count_up(
      input logic [WIDTH-1:0] cur,
      input logic             top
   );
      if (top)
         return SATURATE ? ALL_ONES : ZERO;
      return cur + ONE;
   endfunction

   function automatic logic [WIDTH-1:0] count_down(
      input logic [WIDTH-1:0] cur,
      input logic             bottom
   );
      if (bottom)
         return SATURATE ? ZERO : ALL_ONES;
      return cur - ONE;
   endfunction

   assign at_max = (q_p0 == ALL_ONES);
   assign at_min = (q_p0 == ZERO);

   always_comb begin
      q_nxt  = q_p0;
      co_nxt = 1'b0;
      if (load) begin
         q_nxt = d;
      end else if (en) begin
         case (mode_e'(mode))
            MODE_JK: begin
               q_nxt = jk_update(q_p0, j, k);
            end
            MODE_UP: begin
               q_nxt  = count_up(q_p0, at_max);
               co_nxt = at_max;
            end
            MODE_DOWN: begin
               q_nxt  = count_down(q_p0, at_min);
               co_nxt = at_min;
            end
            MODE_SHL: begin
               q_nxt  = {q_p0[WIDTH-2:0], sin};
               co_nxt = q_p0[WIDTH-1];
            end
            default: begin
               q_nxt  = q_p0;
               co_nxt = 1'b0;
            end
         endcase
      end
   end

   // Stage p0: the only state; captured on the falling edge, cleared asynchronously.
   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         q_p0  <= RESET_VAL;
         co_p0 <= 1'b0;
      end else begin
         q_p0  <= q_nxt;
         co_p0 <= co_nxt;
      end
   end

   assign q     = q_p0;
   assign q_bar = ~q_p0;
   assign co    = co_p0;
   assign tc    = ((mode_e'(mode) == MODE_UP) && at_max) ||
                  ((mode_e'(mode) == MODE_DOWN) && at_min);

endmodule

// File: tb/tb_jk_mode_register.sv
// Scoreboard bench: driver pushes reference results, monitor pops and compares after each falling edge.
module tb_jk_mode_register;

   logic       clk;
   logic       clr;
   logic       en;
   logic       load;
   logic [1:0] mode;
   logic [3:0] j, k, d;
   logic       sin;
   logic [3:0] q_w, qb_w, q_s, qb_s;
   logic       tc_w, co_w, tc_s, co_s;

   jk_mode_register #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .clr(clr), .en(en), .load(load), .mode(mode), .j(j), .k(k), .d(d),
      .sin(sin), .q(q_w), .q_bar(qb_w), .tc(tc_w), .co(co_w));

   jk_mode_register #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b1)) u_sat (
      .clk(clk), .clr(clr), .en(en), .load(load), .mode(mode), .j(j), .k(k), .d(d),
      .sin(sin), .q(q_s), .q_bar(qb_s), .tc(tc_s), .co(co_s));

   typedef struct {
      int idx;
      int qw;
      bit cw;
      bit tw;
      int qs;
      bit cs;
      bit ts;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mq_w, mq_s;
   int   step_no = 0;
   bit   edge_on = 0;

   initial clk = 1'b1;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: arithmetic on integers, one rule per mode.
   function automatic void ref_next(input bit sat, input int qc, input bit ld, input bit en_i,
                                    input int md, input int jv, input int kv, input int dv,
                                    input bit s, output int qn, output bit con);
      con = 0;
      qn  = qc;
      if (ld) qn = dv;
      else if (en_i) begin
         case (md)
            0: begin
               qn = 0;
               for (int i = 0; i < 4; i++) begin
                  int jb, kb, qb, nb;
                  jb = (jv >> i) & 1;
                  kb = (kv >> i) & 1;
                  qb = (qc >> i) & 1;
                  if (jb == 1 && kb == 1) nb = 1 - qb;
                  else if (jb == 1)       nb = 1;
                  else if (kb == 1)       nb = 0;
                  else                    nb = qb;
                  qn = qn + (nb << i);
               end
            end
            1: if (qc == 15) begin con = 1; qn = sat ? 15 : 0; end
               else qn = qc + 1;
            2: if (qc == 0) begin con = 1; qn = sat ? 0 : 15; end
               else qn = qc - 1;
            default: begin
               qn  = (qc * 2 + s) % 16;
               con = (qc >= 8);
            end
         endcase
      end
   endfunction

   function automatic bit ref_tc(input int md, input int qv);
      return (md == 1 && qv == 15) || (md == 2 && qv == 0);
   endfunction

   task automatic apply(input bit ld, input bit en_i, input int md, input int jv,
                        input int kv, input int dv, input bit s);
      exp_t e;
      load = ld; en = en_i; mode = 2'(md);
      j = 4'(jv); k = 4'(kv); d = 4'(dv); sin = s;
      step_no++;
      e.idx = step_no;
      ref_next(1'b0, mq_w, ld, en_i, md, jv, kv, dv, s, e.qw, e.cw);
      ref_next(1'b1, mq_s, ld, en_i, md, jv, kv, dv, s, e.qs, e.cs);
      e.tw = ref_tc(md, e.qw);
      e.ts = ref_tc(md, e.qs);
      mq_w = e.qw;
      mq_s = e.qs;
      sb.push_back(e);
   endtask

   task automatic step(input bit ld, input bit en_i, input int md, input int jv,
                       input int kv, input int dv, input bit s);
      @(posedge clk);
      #1;
      apply(ld, en_i, md, jv, kv, dv, s);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      #2;
      check("drain_queue_empty", sb.size(), 0);
   endtask

   // Monitor: one expected entry per falling edge while stimulus is streaming.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("s%0d_q_wrap", e.idx),   q_w,  e.qw);
            check($sformatf("s%0d_qbar_wrap", e.idx), qb_w, (~e.qw) & 15);
            check($sformatf("s%0d_co_wrap", e.idx),  co_w, e.cw);
            check($sformatf("s%0d_tc_wrap", e.idx),  tc_w, e.tw);
            check($sformatf("s%0d_q_sat", e.idx),    q_s,  e.qs);
            check($sformatf("s%0d_qbar_sat", e.idx), qb_s, (~e.qs) & 15);
            check($sformatf("s%0d_co_sat", e.idx),   co_s, e.cs);
            check($sformatf("s%0d_tc_sat", e.idx),   tc_s, e.ts);
         end
      end
   end

   // Rising edges alone must never move q.
   initial begin
      forever begin
         int snap_w, snap_s;
         @(negedge clk);
         #1;
         snap_w = q_w;
         snap_s = q_s;
         @(posedge clk);
         #2;
         if (edge_on && !clr) begin
            check("rise_hold_wrap", q_w, snap_w);
            check("rise_hold_sat", q_s, snap_s);
         end
      end
   end

   initial begin
      clr = 1'b1; en = 0; load = 0; mode = 0; j = 0; k = 0; d = 0; sin = 0;
      mq_w = 0; mq_s = 0;
      #2;
      check("reset_q", q_w, 0);
      check("reset_qbar", qb_w, 4'hF);
      check("reset_co", co_w, 0);
      check("reset_tc", tc_w, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      edge_on = 1;

      // Per-bit JK, then double toggle returns to the same value.
      step(1, 1, 0, 0, 0, 4'b0101, 0);
      step(0, 1, 0, 4'b1100, 4'b1010, 0, 0);
      step(0, 1, 0, 4'hF, 4'hF, 0, 0);
      step(0, 1, 0, 4'hF, 4'hF, 0, 0);
      // Count up through the top.
      step(1, 1, 1, 0, 0, 4'hE, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      // Count down through zero.
      step(1, 1, 2, 0, 0, 4'h1, 0);
      step(0, 1, 2, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0, 0);
      // Shift left.
      step(1, 1, 3, 0, 0, 4'b1001, 0);
      step(0, 1, 3, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0, 0, 1);
      // Load with en low, then hold.
      step(1, 0, 1, 0, 0, 4'h7, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 2, 0, 0, 0, 1);
      step(0, 0, 3, 0, 0, 0, 1);

      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(7) == 0), ($urandom_range(7) != 0), int'($urandom_range(3)),
              int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
              1'($urandom_range(1)));
      end

      // Asynchronous clear mid-operation, clk held high.
      step(1, 1, 0, 0, 0, 4'hA, 0);
      drain();
      @(posedge clk);
      #1;
      load = 1; d = 4'h3; en = 1; mode = 2'b01;
      clr = 1'b1;
      #1;
      check("clr_async_q", q_w, 0);
      check("clr_async_qbar", qb_w, 4'hF);
      check("clr_async_co", co_w, 0);
      check("clr_async_q_sat", q_s, 0);
      repeat (2) @(negedge clk);
      #1;
      check("clr_held_q", q_w, 0);
      check("clr_held_co", co_w, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      mq_w = 0;
      mq_s = 0;
      apply(1, 1, 1, 0, 0, 4'h3, 0);
      step(0, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_mode_register.md
JK_MODE_REGISTER -- requirements
Module: jk_mode_register

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded by reset.
REQ-003 Parameter SATURATE, default 0: 0 = count modes wrap, 1 = count modes saturate.
REQ-004 clk  input  1  single clock; all state updates occur on the falling edge (master-slave timing: inputs settle while clk high, outputs change on high-to-low transition).
REQ-005 clr  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  update enable; 0 = hold.
REQ-007 load  input  1  synchronous parallel load; overrides mode.
REQ-008 mode  input  2  00 per-bit JK, 01 count up, 10 count down, 11 shift left.
REQ-009 j  input  WIDTH  per-bit J inputs (mode 00).
REQ-010 k  input  WIDTH  per-bit K inputs (mode 00).
REQ-011 d  input  WIDTH  parallel load data.
REQ-012 sin  input  1  serial input to bit 0 (mode 11).
REQ-013 q  output  WIDTH  registered state.
REQ-014 q_bar  output  WIDTH  bitwise complement of q at all times.
REQ-015 tc  output  1  terminal count, combinational from q and mode.
REQ-016 co  output  1  registered carry/event flag, one-cycle pulse.

Function
REQ-017 Priority at each falling clk edge: clr > load > en=0 > mode.
REQ-018 load=1 (en ignored): q <= d; co <= 0.
REQ-019 en=0, load=0: q holds; co <= 0.
REQ-020 Mode 00, per bit i: (j,k)=00 hold, 01 clear, 10 set, 11 toggle; bits independent; co <= 0.
REQ-021 Mode 01: q <= q+1 modulo 2^WIDTH; when q is all ones: SATURATE=0 -> q <= 0, co <= 1; SATURATE=1 -> q holds all ones, co <= 1; otherwise co <= 0.
REQ-022 Mode 10: q <= q-1 modulo 2^WIDTH; when q is zero: SATURATE=0 -> q <= all ones, co <= 1; SATURATE=1 -> q holds 0, co <= 1; otherwise co <= 0.
REQ-023 Mode 11: q <= {q[WIDTH-2:0], sin}; co <= previous q[WIDTH-1].
REQ-024 tc = 1 iff (mode=01 and q all ones) or (mode=10 and q=0); 0 in modes 00 and 11; independent of en and load.
REQ-025 Mode change takes effect at the next falling edge; no state beyond q and co; no rising-edge behaviour.
REQ-026 co pulses stay high for exactly one clk period when the event condition is not repeated; consecutive saturating edges keep co high.
REQ-027 q_bar is derived from q (never separately registered); q and q_bar never both 1 in any bit.

Reset
REQ-028 clr=1 forces q=RESET_VAL, q_bar=~RESET_VAL, co=0 immediately, independent of clk.
REQ-029 While clr=1 all falling edges are ignored; first update occurs at the first falling edge after clr deasserts.
REQ-030 clr asserted mid-operation (any mode, load active) aborts the operation with no partial update.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
REQ-031 clr pulse with clk idle high, q previously 4'hA -> q=0, q_bar=4'hF, co=0 without a clk edge.
REQ-032 Mode 00, q=4'b0101, j=4'b1100, k=4'b1010, en=1 -> after one falling edge q=4'b1101; k=j=4'hF twice -> q returns to 4'b1101.
REQ-033 Mode 01, SATURATE=0, load d=4'hE then count -> q=F with tc=1, next edge q=0, co=1 for one cycle, then q=1, co=0.
REQ-034 Mode 10, SATURATE=1, from q=1 -> q=0 with tc=1, next two edges q stays 0, co=1 on both.
REQ-035 Mode 11, q=4'b1001, sin=0,1 on successive edges -> q=4'b0010 with co=1, then q=4'b0101 with co=0.
REQ-036 en=0 with load=1, d=4'h7 -> q=7 at next falling edge; en=0, load=0 -> q holds over 3 edges, co=0; rising edges alone never change q.
